regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, ...).
//  Arbitrates round-robin with a valid/ready handshake, registers the winning write and drives WriteReg/ALUResult/RegWrite.
//  Rejects non-existent register addresses (13..15) and flags read-after-write hazards against the in-flight write.
// PARAMETERS
//  NUM_REQ   3    number of writeback requesters (2..8)
//  NUM_GPR   13   implemented registers; valid addresses 0..NUM_GPR-1
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous, active-low reset
//  stall        in   1           1 = block new grants this cycle (all req_ready=0)
//  req_valid    in   NUM_REQ     requester i has a write pending
//  req_addr     in   4*NUM_REQ   dest register of requester i, slice [4i+:4]
//  req_data     in   32*NUM_REQ  write data of requester i, slice [32i+:32]
//  req_ready    out  NUM_REQ     one-hot (or zero) grant; transfer when valid&ready at clk edge
//  A1, A2       in   4           register-file read addresses, hazard check only
//  WriteReg     out  4           register-file write address (registered)
//  ALUResult    out  32          register-file write data (registered)
//  RegWrite     out  1           register-file write enable (registered)
//  hazard1/2    out  1           comb: RegWrite & WriteReg==A1 / A2 (read sees stale value)
//  err_addr     out  1           1-cycle pulse: accepted request had addr >= NUM_GPR
//  err_id       out  3           index of offending requester, valid while err_addr=1
// BEHAVIOUR
//  - Reset (rst=0, async): RegWrite=0, WriteReg=0, ALUResult=0, err_addr=0, err_id=0; priority pointer=0.
//  - req_ready is combinational from req_valid, stall and the pointer.
//  - At most one bit of req_ready is set. It is the first valid requester at or after the pointer, mod NUM_REQ.
//  - stall=1: req_ready=0. The pointer holds. The registered outputs load the idle value at the next edge (RegWrite=0).
//  - Transfer on requester g at edge N, addr < NUM_GPR:
//      RegWrite=1, WriteReg=addr, ALUResult=data during cycle N+1.
//      The register file commits at edge N+1 (1-cycle latency).
//  - Transfer with addr >= NUM_GPR: the requester is still acked (no deadlock).
//      RegWrite=0, err_addr=1, err_id=g during cycle N+1.
//  - Pointer update: after any transfer on g, pointer <= (g+1) mod NUM_REQ. No transfer -> pointer holds.
//  - No transfer in a cycle -> RegWrite=0 next cycle. Outputs never hold a stale write for 2 cycles.
//  - Requesters must hold valid/addr/data stable until acked. The arbiter does not buffer beyond the output register.
//  - Several requesters with the same addr in one cycle: served in round-robin order.
//      Later grants overwrite earlier ones; this is not an error.
//  - Back-to-back throughput: 1 write per cycle, sustained, while any valid=1 and stall=0.
//  - hazard1/hazard2 are 0 whenever RegWrite=0. A1/A2 >= NUM_GPR never raises a hazard.
//  - Reset asserted mid-transfer: the pending write is dropped, RegWrite=0 immediately (async).
//      No write reaches the register file.
// STRUCTURE
//  - Package regfile_pkg: REG_ADDR_W=4, DATA_W=32, NUM_GPR=13, typedef logic [3:0] reg_addr_t,
//    typedef logic [31:0] reg_data_t. Shared with the register file and decode.
//  - Sub-module rr_arbiter #(N): req vector + pointer in -> one-hot grant + grant index out (combinational).
//    The pointer register lives in regfile_wb_arbiter.
//  - Top: rr_arbiter, grant-index mux for addr/data, addr range check, output/err registers, hazard compare.
// TESTING
//  1. Reset: rst=0 with all req_valid=1 -> RegWrite=0, ALUResult=0, req_ready=0 while in reset.
//     Release -> req0 granted first.
//  2. Single write: req1 valid, addr=5, data=0xDEADBEEF.
//     -> ready1 for 1 cycle; next cycle RegWrite=1, WriteReg=5, ALUResult=0xDEADBEEF; then RegWrite=0.
//  3. Fairness: all 3 valid for 6 cycles, stall=0.
//     -> grants in order 0,1,2,0,1,2; RegWrite=1 for 6 consecutive cycles.
//  4. Stall: 2 valid, stall=1 for 3 cycles.
//     -> req_ready=0, RegWrite=0, pointer unchanged. First grant after release goes to the same requester as before the stall.
//  5. Bad address: req2 addr=14.
//     -> ready2=1; next cycle RegWrite=0, err_addr=1, err_id=2 for exactly 1 cycle.
//  6. Hazard: write to r3 in flight, A1=3, A2=4 -> hazard1=1, hazard2=0.
//     Same compare with RegWrite=0 -> both 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants, used by the writeback arbiter,
// the register file and decode.
package regfile_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 32;
   localparam int NUM_GPR    = 13;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     reg_data_t;

   function automatic logic addr_ok(input reg_addr_t addr, input int num_gpr);
      return int'(addr) < num_gpr;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr (mod N).
// The pointer register is owned by the caller.
module rr_arbiter #(
   parameter  int N     = 3,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] w_cand [N];

   // w_cand[k] is the requester index examined at search position k
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         assign w_cand[gi] = IDX_W'((int'(ptr) + gi) % N);
      end
   endgenerate

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!grant_any && req[w_cand[k]]) begin
            grant[w_cand[k]] = 1'b1;
            grant_idx        = w_cand[k];
            grant_any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port among NUM_REQ writeback sources,
// with registered write outputs, address range checking and RAW hazard flags.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int NUM_GPR = regfile_pkg::NUM_GPR
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [REG_ADDR_W-1:0]        A1,
   input  logic [REG_ADDR_W-1:0]        A2,
   output logic [REG_ADDR_W-1:0]        WriteReg,
   output logic [DATA_W-1:0]            ALUResult,
   output logic                         RegWrite,
   output logic                         hazard1,
   output logic                         hazard2,
   output logic                         err_addr,
   output logic [2:0]                   err_id
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   reg_addr_t        w_addr_arr [NUM_REQ];
   reg_data_t        w_data_arr [NUM_REQ];
   logic [NUM_REQ-1:0] w_req_eff;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0] w_gidx;
   logic             w_any;
   reg_addr_t        w_sel_addr;
   reg_data_t        w_sel_data;
   logic             w_addr_ok;
   logic             w_do_write;
   logic             w_do_err;
   logic [IDX_W-1:0] w_ptr_next;

   logic [IDX_W-1:0] r_ptr;
   logic             r_regwrite;
   reg_addr_t        r_writereg;
   reg_data_t        r_aluresult;
   logic             r_err_addr;
   logic [2:0]       r_err_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_addr_arr[gi] = req_addr[REG_ADDR_W*gi +: REG_ADDR_W];
         assign w_data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
      end
   endgenerate

   // No grants while stalled or held in reset
   assign w_req_eff = req_valid & {NUM_REQ{~stall & rst}};

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (w_req_eff),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .grant_any (w_any)
   );

   assign req_ready  = w_grant;
   assign w_sel_addr = w_addr_arr[w_gidx];
   assign w_sel_data = w_data_arr[w_gidx];
   assign w_addr_ok  = addr_ok(w_sel_addr, NUM_GPR);
   assign w_do_write = w_any & w_addr_ok;
   assign w_do_err   = w_any & ~w_addr_ok;
   assign w_ptr_next = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

   // Out-of-range requests are still acked so the requester cannot deadlock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= '0;
         r_regwrite  <= 1'b0;
         r_writereg  <= '0;
         r_aluresult <= '0;
         r_err_addr  <= 1'b0;
         r_err_id    <= '0;
      end else begin
         r_regwrite  <= w_do_write;
         r_writereg  <= w_do_write ? w_sel_addr : '0;
         r_aluresult <= w_do_write ? w_sel_data : '0;
         r_err_addr  <= w_do_err;
         r_err_id    <= w_do_err ? 3'(w_gidx) : 3'd0;
         if (w_any) begin
            r_ptr <= w_ptr_next;
         end
      end
   end

   assign RegWrite  = r_regwrite;
   assign WriteReg  = r_writereg;
   assign ALUResult = r_aluresult;
   assign err_addr  = r_err_addr;
   assign err_id    = r_err_id;

   assign hazard1 = r_regwrite && (r_writereg == A1) && addr_ok(A1, NUM_GPR);
   assign hazard2 = r_regwrite && (r_writereg == A2) && addr_ok(A2, NUM_GPR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a round-robin reference model queues the
// expected write/error outputs each cycle; they are compared after the following edge.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int NGPR = 13;

   logic          clk;
   logic          rst;
   logic          stall;
   logic [2:0]    req_valid;
   logic [11:0]   req_addr;
   logic [95:0]   req_data;
   logic [2:0]    req_ready;
   logic [3:0]    A1, A2;
   logic [3:0]    WriteReg;
   logic [31:0]   ALUResult;
   logic          RegWrite;
   logic          hazard1, hazard2;
   logic          err_addr;
   logic [2:0]    err_id;

   typedef struct {
      logic        rw;
      logic [3:0]  wr;
      logic [31:0] d;
      logic        err;
      logic [2:0]  id;
   } exp_t;

   exp_t       sb [$];
   int         m_ptr;
   int         n_checks;
   int         n_errors;
   logic [2:0] obs_ready;
   int         rw_cnt;

   regfile_wb_arbiter #(.NUM_REQ(NREQ), .NUM_GPR(NGPR)) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .A1        (A1),
      .A2        (A2),
      .WriteReg  (WriteReg),
      .ALUResult (ALUResult),
      .RegWrite  (RegWrite),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .err_addr  (err_addr),
      .err_id    (err_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock: predict grant before the edge, push expected outputs, compare after the edge
   task automatic cycle();
      int   g;
      exp_t e;
      logic [3:0] a;
      @(negedge clk);
      g = -1;
      if (rst && !stall) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      obs_ready = req_ready;
      check_val("req_ready", {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
      e = '{rw: 1'b0, wr: 4'd0, d: 32'd0, err: 1'b0, id: 3'd0};
      if (g >= 0) begin
         a = req_addr[4*g +: 4];
         if (int'(a) < NGPR) begin
            e.rw = 1'b1;
            e.wr = a;
            e.d  = req_data[32*g +: 32];
         end else begin
            e.err = 1'b1;
            e.id  = 3'(g);
         end
         m_ptr = (g + 1) % NREQ;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("cycle t=%0t ready=%b RegWrite=%b WriteReg=%0d ALUResult=%h err=%b id=%0d",
               $time, obs_ready, RegWrite, WriteReg, ALUResult, err_addr, err_id);
      check_val("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
      if (e.rw) begin
         check_val("WriteReg", {28'd0, WriteReg}, {28'd0, e.wr});
         check_val("ALUResult", ALUResult, e.d);
      end
      check_val("err_addr", {31'd0, err_addr}, {31'd0, e.err});
      if (e.err) check_val("err_id", {29'd0, err_id}, {29'd0, e.id});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      m_ptr     = 0;
      rw_cnt    = 0;
      rst       = 1'b0;
      stall     = 1'b0;
      req_valid = 3'b111;
      req_addr  = {4'd2, 4'd1, 4'd0};
      req_data  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      A1        = 4'd0;
      A2        = 4'd0;

      // Held in reset with every requester valid
      #22;
      check_val("rst_ready", {29'd0, req_ready}, 32'd0);
      check_val("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
      check_val("rst_ALUResult", ALUResult, 32'd0);
      check_val("rst_err_addr", {31'd0, err_addr}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Fairness: fixed order 0,1,2,0,1,2 with back-to-back writes
      for (int i = 0; i < 6; i++) begin
         cycle();
         check_val("fair_order", {29'd0, obs_ready}, 32'd1 << (i % 3));
         if (RegWrite) rw_cnt++;
      end
      check_val("fair_rw_count", rw_cnt, 32'd6);
      req_valid = 3'b000;
      cycle();

      // Single write from requester 1
      req_valid = 3'b010;
      req_addr[7:4]   = 4'd5;
      req_data[63:32] = 32'hDEADBEEF;
      cycle();
      check_val("t2_ready", {29'd0, obs_ready}, 32'b010);
      check_val("t2_WriteReg", {28'd0, WriteReg}, 32'd5);
      check_val("t2_ALUResult", ALUResult, 32'hDEADBEEF);
      req_valid = 3'b000;
      cycle();
      check_val("t2_idle", {31'd0, RegWrite}, 32'd0);

      // Stall: pointer is at 2, so req0 wins once the stall lifts
      req_valid = 3'b011;
      stall     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_val("stall_ready", {29'd0, obs_ready}, 32'd0);
      end
      stall = 1'b0;
      cycle();
      check_val("stall_release", {29'd0, obs_ready}, 32'b001);
      req_valid = 3'b000;
      cycle();

      // Out-of-range destination from requester 2
      req_valid = 3'b100;
      req_addr[11:8] = 4'd14;
      cycle();
      check_val("bad_ready", {29'd0, obs_ready}, 32'b100);
      check_val("bad_err", {31'd0, err_addr}, 32'd1);
      check_val("bad_id", {29'd0, err_id}, 32'd2);
      check_val("bad_rw", {31'd0, RegWrite}, 32'd0);
      req_valid = 3'b000;
      cycle();
      check_val("bad_pulse", {31'd0, err_addr}, 32'd0);

      // Hazard against an in-flight write to r3
      req_valid = 3'b001;
      req_addr[3:0] = 4'd3;
      A1 = 4'd3;
      A2 = 4'd4;
      cycle();
      check_val("haz1_on", {31'd0, hazard1}, 32'd1);
      check_val("haz2_off", {31'd0, hazard2}, 32'd0);
      A2 = 4'd3;
      #1;
      check_val("haz2_on", {31'd0, hazard2}, 32'd1);
      req_valid = 3'b000;
      cycle();
      check_val("haz1_idle", {31'd0, hazard1}, 32'd0);
      check_val("haz2_idle", {31'd0, hazard2}, 32'd0);

      // Randomised traffic through the same model
      for (int i = 0; i < 40; i++) begin
         req_valid = 3'($urandom_range(0, 7));
         stall     = ($urandom_range(0, 4) == 0);
         req_addr  = 12'($urandom);
         req_data  = {$urandom, $urandom, $urandom};
         A1        = 4'($urandom);
         cycle();
         check_val("rnd_haz1", {31'd0, hazard1},
                   {31'd0, RegWrite && (WriteReg == A1) && (int'(A1) < NGPR)});
      end
      stall = 1'b0;

      // Asynchronous reset while a write is presented
      req_valid = 3'b001;
      req_addr[3:0]  = 4'd7;
      req_data[31:0] = 32'h12345678;
      cycle();
      #2;
      rst = 1'b0;
      #1;
      check_val("async_rw", {31'd0, RegWrite}, 32'd0);
      check_val("async_ready", {29'd0, req_ready}, 32'd0);
      req_valid = 3'b000;
      sb.delete();
      @(posedge clk);
      #1;
      rst   = 1'b1;
      m_ptr = 0;
      cycle();
      check_val("post_rst_rw", {31'd0, RegWrite}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
